uart_rx_fifo: RTL and testbench

- Receive buffer directly downstream of uart_receiver.
- Captures each completed frame (8-bit data plus stop-bit error flag) and queues it in a first-word-fall-through FIFO.
- Presents entries to the bus/CPU side through a valid/ready read port.
- Tracks overrun and frame-error statistics, so the consumer need not service every byte the cycle it arrives.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rx_fifo_mem.sv | 19 +
 rtl/uart_rx_fifo.sv | 66 ++++++
 tb/tb_uart_rx_fifo.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef struct packed {
    logic                   error;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: DEPTH-entry storage with one write port and an async read port
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  uart_rx_entry_t wdata,
  input  logic [AW-1:0]  raddr,
  output uart_rx_entry_t rdata
);
  uart_rx_entry_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive buffer with overrun flag and saturating frame-error counter
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ERR_CNT_W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_data_valid,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_error,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_error,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic [ERR_CNT_W-1:0]   err_count,
  input  logic                   err_count_clr
);
  logic           valid_q, push_req, pop, wr_en, drop;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count_nxt;
  uart_rx_entry_t wdata, rdata;
  assign push_req  = rx_data_valid && !valid_q;
  assign pop       = rd_valid && rd_ready;
  assign wr_en     = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign full      = count == CW'(DEPTH);
  assign rd_valid  = count != '0;
  assign wdata     = '{error: rx_error, data: rx_data};
  assign rd_data   = rdata.data;
  assign rd_error  = rdata.error;
  assign count_nxt = (wr_en && !pop) ? count + 1'b1 : (!wr_en && pop) ? count - 1'b1 : count;
  uart_rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      valid_q <= rx_data_valid;
      count   <= count_nxt;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      overrun <= drop ? 1'b1 : overrun_clr ? 1'b0 : overrun;
      // clear takes precedence over a same-cycle error frame
      err_count <= err_count_clr ? '0 :
                   (push_req && rx_error && err_count != '1) ? err_count + 1'b1 : err_count;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table vectors plus scoreboard-checked sequences for uart_rx_fifo
module tb_uart_rx_fifo;
  import uart_pkg::*;
  localparam int DEPTH = 16;
  logic       clk = 1'b0, rst = 1'b1;
  logic       rx_data_valid = 1'b0, rx_error = 1'b0, rd_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       overrun_clr = 1'b0, err_count_clr = 1'b0;
  logic       rd_valid, rd_error, full, overrun;
  logic [7:0] rd_data, err_count;
  logic [4:0] count;
  int checks = 0, failures = 0;
  uart_rx_entry_t sb[$];
  int  merr = 0;
  logic mover = 1'b0, prev_valid = 1'b0;
  typedef struct {
    logic v; logic [7:0] d; logic e; logic rdy;
    int exp_count; logic exp_valid;
  } vec_t;
  vec_t tbl[14];

  uart_rx_fifo #(.DEPTH(DEPTH), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rx_data_valid(rx_data_valid), .rx_data(rx_data),
    .rx_error(rx_error), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_error(rd_error), .count(count), .full(full),
    .overrun(overrun), .overrun_clr(overrun_clr), .err_count(err_count),
    .err_count_clr(err_count_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic e, input logic rdy);
    logic push, pop, was_full;
    uart_rx_entry_t x;
    rx_data_valid = v; rx_data = d; rx_error = e; rd_ready = rdy;
    push = v && !prev_valid;
    was_full = sb.size() == DEPTH;
    pop = rdy && sb.size() != 0;
    if (pop) begin
      x = sb.pop_front();
      chk("rd_data", rd_data, x.data);
      chk("rd_error", rd_error, x.error);
    end
    if (push && (!was_full || pop)) sb.push_back('{error: e, data: d});
    if (push && was_full && !pop) mover = 1'b1;
    else if (overrun_clr) mover = 1'b0;
    if (err_count_clr) merr = 0;
    else if (push && e && merr < 255) merr++;
    prev_valid = v;
    @(posedge clk); #1;
    chk("count", count, sb.size());
    chk("rd_valid", rd_valid, sb.size() != 0);
    chk("full", full, sb.size() == DEPTH);
    chk("overrun", overrun, mover);
    chk("err_count", err_count, merr);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic e, input logic rdy);
    cycle(1'b1, d, e, rdy);
    cycle(1'b0, 8'h00, 1'b0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb.size() != 0; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("drain_done", count, 0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0};
    for (int i = 3; i < 13; i++) tbl[i] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", count, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_full", full, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_err_count", err_count, 0);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].rdy);
      chk("tbl_count", count, tbl[i].exp_count);
      chk("tbl_rd_valid", rd_valid, tbl[i].exp_valid);
    end
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0, 1'b0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    push_byte(8'hFF, 1'b0, 1'b0);
    chk("drop_overrun", overrun, 1);
    chk("drop_count", count, 16);
    drain();
    overrun_clr = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    overrun_clr = 1'b0;
    chk("overrun_cleared", overrun, 0);
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    chk("full_pushpop_overrun", overrun, 0);
    chk("full_pushpop_count", count, 16);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) push_byte(8'(8'h60 + i), 1'(i % 3 == 0), 1'b1);
    drain();
    for (int i = 0; i < 16; i++) push_byte(8'(8'hB0 + i), 1'b0, 1'b0);
    overrun_clr = 1'b1;
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    overrun_clr = 1'b0;
    chk("overrun_set_wins", overrun, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    err_count_clr = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    err_count_clr = 1'b0;
    for (int i = 0; i < 300; i++) push_byte(8'(i), 1'b1, 1'b1);
    chk("err_saturated", err_count, 8'hFF);
    err_count_clr = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    err_count_clr = 1'b0;
    chk("err_cleared", err_count, 0);
    err_count_clr = 1'b1;
    cycle(1'b1, 8'h12, 1'b1, 1'b0);
    err_count_clr = 1'b0;
    chk("err_clr_wins", err_count, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 7; i++) push_byte(8'(8'h40 + i), 1'b1, 1'b0);
    push_byte(8'hF0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pre_reset_count", count, 7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_rd_valid", rd_valid, 0);
    chk("async_rst_overrun", overrun, 0);
    chk("async_rst_err_count", err_count, 0);
    sb.delete(); merr = 0; mover = 1'b0; prev_valid = 1'b0;
    rx_data_valid = 1'b1; rx_data = 8'h81; rx_error = 1'b0; rd_ready = 1'b0;
    #2 rst = 1'b0;
    cycle(1'b1, 8'h81, 1'b0, 1'b0);
    chk("post_rst_count", count, 1);
    chk("post_rst_head", rd_data, 8'h81);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    push_byte(8'h82, 1'b0, 1'b0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
